// File: rtl/tg_sequencer.sv
// -----------------------------------------------------------------------------
// tg_sequencer
// Major-cycle timing generator for the PDP-8/I processor model. Steps through
// the time states TS1..TS4 (each held for TSn_CYC clocks) and emits a
// one-clock time pulse TPn on the last clock of each state. Holds the RUN
// flip-flop and reacts to the console START / CONTINUE / STOP / SINGLE STEP
// controls.
//
// Optional feature macro: TG_SLOW_CYCLE_EN
//   defined     : 'pause' stretches TS3 by freezing its counter while the
//                 counter is non-zero.
//   not defined : 'pause' is ignored and no hold logic is built.
//
// Parameters:
//   TS1_CYC..TS4_CYC : clocks spent in each time state (legal range 2..255)
//
// Ports:
//   clk        in  : system clock, rising edge
//   reset_n    in  : synchronous active-low reset
//   key_start  in  : console START, one-clock pulse
//   key_cont   in  : console CONTINUE, one-clock pulse
//   key_stop   in  : console STOP, level or pulse
//   sing_step  in  : SINGLE STEP switch, level
//   pause      in  : slow-cycle hold request, level
//   run        out : RUN flip-flop
//   ts1..ts4   out : time-state levels, one-hot or all zero
//   tp1..tp4   out : one-clock time pulses, last clock of each state
//   busy       out : high while any time state is active
//
// All outputs are decoded from registered state only; no input reaches an
// output without passing through a flip-flop.
// -----------------------------------------------------------------------------
module tg_sequencer #(
   parameter int TS1_CYC = 20,
   parameter int TS2_CYC = 20,
   parameter int TS3_CYC = 20,
   parameter int TS4_CYC = 20
) (
   input  logic clk,
   input  logic reset_n,
   input  logic key_start,
   input  logic key_cont,
   input  logic key_stop,
   input  logic sing_step,
   input  logic pause,
   output logic run,
   output logic ts1,
   output logic ts2,
   output logic ts3,
   output logic ts4,
   output logic tp1,
   output logic tp2,
   output logic tp3,
   output logic tp4,
   output logic busy
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_TS1  = 3'd1,
      S_TS2  = 3'd2,
      S_TS3  = 3'd3,
      S_TS4  = 3'd4
   } state_t;

   // Counter load values: the state ends on the clock where the counter is 0.
   localparam logic [7:0] LD1 = 8'(TS1_CYC - 1);
   localparam logic [7:0] LD2 = 8'(TS2_CYC - 1);
   localparam logic [7:0] LD3 = 8'(TS3_CYC - 1);
   localparam logic [7:0] LD4 = 8'(TS4_CYC - 1);

   state_t     state, state_next;
   logic [7:0] cnt, cnt_next;
   logic       run_next;
   logic       cnt_zero;
   logic       hold;

   assign cnt_zero = (cnt == 8'd0);

`ifdef TG_SLOW_CYCLE_EN
   // Freeze only before the final TS3 clock, so tp3 can never be skipped.
   assign hold = (state == S_TS3) && !cnt_zero && pause;
`else
   logic unused_pause;
   assign unused_pause = pause;
   assign hold         = 1'b0;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= S_IDLE;
         cnt   <= 8'd0;
         run   <= 1'b0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         run   <= run_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      run_next   = run;
      // STOP clears RUN at any time; the cycle in progress still completes.
      if (key_stop) run_next = 1'b0;
      case (state)
         S_IDLE: begin
            // STOP in the same clock as START/CONTINUE wins.
            if ((key_start || key_cont) && !key_stop) begin
               run_next   = 1'b1;
               state_next = S_TS1;
               cnt_next   = LD1;
            end
         end
         S_TS1: begin
            if (cnt_zero) begin
               state_next = S_TS2;
               cnt_next   = LD2;
            end else begin
               cnt_next = cnt - 8'd1;
            end
         end
         S_TS2: begin
            if (cnt_zero) begin
               state_next = S_TS3;
               cnt_next   = LD3;
            end else begin
               cnt_next = cnt - 8'd1;
            end
         end
         S_TS3: begin
            if (cnt_zero) begin
               state_next = S_TS4;
               cnt_next   = LD4;
            end else if (!hold) begin
               cnt_next = cnt - 8'd1;
            end
         end
         S_TS4: begin
            if (cnt_zero) begin
               if (sing_step) run_next = 1'b0;
               // Decision uses RUN as it will be after this edge.
               if (run_next) begin
                  state_next = S_TS1;
                  cnt_next   = LD1;
               end else begin
                  state_next = S_IDLE;
                  cnt_next   = 8'd0;
               end
            end else begin
               cnt_next = cnt - 8'd1;
            end
         end
         default: begin
            state_next = S_IDLE;
            cnt_next   = 8'd0;
            run_next   = 1'b0;
         end
      endcase
   end

   // Output decode (registered state only)
   always_comb begin
      ts1  = (state == S_TS1);
      ts2  = (state == S_TS2);
      ts3  = (state == S_TS3);
      ts4  = (state == S_TS4);
      tp1  = ts1 && cnt_zero;
      tp2  = ts2 && cnt_zero;
      tp3  = ts3 && cnt_zero;
      tp4  = ts4 && cnt_zero;
      busy = (state != S_IDLE);
   end

endmodule
